dmem_access_unit: RTL

- Sits directly downstream of the pipelined CPU's MEM stage, between the core's data-memory port and a variable-latency data-memory bus.
- Converts each load/store into one byte-enabled, word-aligned bus transaction and performs load lane extraction and sign/zero extension.
- Holds the pipeline with a stall output until the access completes.
- Flags misaligned accesses and bus timeouts instead of issuing or hanging on them.

---
 rtl/dmem_access_unit.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/dmem_access_unit.sv
// dmem_access_unit: sits behind the MEM stage. Turns one load/store into a
// single word-aligned, byte-enabled bus transaction, extracts and extends
// load lanes, and stalls the pipeline until the access completes. Misaligned
// accesses are flagged without touching the bus; unacknowledged requests are
// abandoned after TIMEOUT cycles in REQ.
module dmem_access_unit #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req,
  input  logic        i_we,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  input  logic [2:0]  i_dmtype,
  output logic [31:0] o_rdata,
  output logic        o_stall,
  output logic        o_misaligned,
  output logic        o_bus_err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_be,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_t;

  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        bus_req_q, bus_req_d;
  logic        bus_we_q, bus_we_d;
  logic [31:0] bus_addr_q, bus_addr_d;
  logic [31:0] bus_wdata_q, bus_wdata_d;
  logic [3:0]  bus_be_q, bus_be_d;
  logic [31:0] o_rdata_q, o_rdata_d;
  logic        mis_q, mis_d;
  logic        err_q, err_d;
  // Access type and byte offset kept for lane extraction when the ack lands.
  logic [2:0]  dmtype_q, dmtype_d;
  logic [1:0]  off_q, off_d;

  logic        is_half, is_byte, is_word, misaligned;
  logic [3:0]  lane_be;
  logic [31:0] lane_wdata;
  logic        ld_half, ld_byte, ld_uns;
  logic [7:0]  ld_b;
  logic [15:0] ld_h;
  logic [31:0] ld_ext;

  // Decode the incoming access: alignment check and store lane placement.
  always_comb begin
    is_half    = (i_dmtype == 3'b001) || (i_dmtype == 3'b010);
    is_byte    = (i_dmtype == 3'b011) || (i_dmtype == 3'b100);
    is_word    = !is_half && !is_byte;
    misaligned = (is_word && (i_addr[1:0] != 2'b00)) || (is_half && i_addr[0]);
    lane_be    = 4'b1111;
    lane_wdata = i_wdata;
    if (is_byte) begin
      lane_be    = 4'b0001 << i_addr[1:0];
      lane_wdata = {4{i_wdata[7:0]}};
    end else if (is_half) begin
      lane_be    = i_addr[1] ? 4'b1100 : 4'b0011;
      lane_wdata = {2{i_wdata[15:0]}};
    end
  end

  // Pick the addressed lane of the returned word and extend it.
  always_comb begin
    ld_half = (dmtype_q == 3'b001) || (dmtype_q == 3'b010);
    ld_byte = (dmtype_q == 3'b011) || (dmtype_q == 3'b100);
    ld_uns  = (dmtype_q == 3'b010) || (dmtype_q == 3'b100);
    ld_b    = bus_rdata[8*off_q +: 8];
    ld_h    = off_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    ld_ext  = bus_rdata;
    if (ld_byte)      ld_ext = {{24{ld_b[7] & ~ld_uns}}, ld_b};
    else if (ld_half) ld_ext = {{16{ld_h[15] & ~ld_uns}}, ld_h};
  end

  // Next-state and output logic; ack takes priority over the timeout.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    bus_be_d    = bus_be_q;
    o_rdata_d   = o_rdata_q;
    dmtype_d    = dmtype_q;
    off_d       = off_q;
    mis_d       = 1'b0;
    err_d       = 1'b0;
    o_stall     = 1'b0;
    case (state_q)
      S_IDLE: begin
        o_stall = i_req;
        if (i_req) begin
          if (misaligned) begin
            mis_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            bus_req_d   = 1'b1;
            bus_we_d    = i_we;
            bus_addr_d  = {i_addr[31:2], 2'b00};
            bus_wdata_d = lane_wdata;
            bus_be_d    = lane_be;
            dmtype_d    = i_dmtype;
            off_d       = i_addr[1:0];
            cnt_d       = 16'd0;
            state_d     = S_REQ;
          end
        end
      end
      S_REQ: begin
        o_stall = 1'b1;
        if (bus_ack) begin
          bus_req_d = 1'b0;
          if (!bus_we_q) o_rdata_d = ld_ext;
          state_d = S_DONE;
        end else if (cnt_q == CNT_LAST) begin
          bus_req_d = 1'b0;
          if (!bus_we_q) o_rdata_d = 32'd0;
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= 16'd0;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= 32'd0;
      bus_wdata_q <= 32'd0;
      bus_be_q    <= 4'd0;
      o_rdata_q   <= 32'd0;
      dmtype_q    <= 3'd0;
      off_q       <= 2'd0;
      mis_q       <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      bus_be_q    <= bus_be_d;
      o_rdata_q   <= o_rdata_d;
      dmtype_q    <= dmtype_d;
      off_q       <= off_d;
      mis_q       <= mis_d;
      err_q       <= err_d;
    end
  end

  assign bus_req      = bus_req_q;
  assign bus_we       = bus_we_q;
  assign bus_addr     = bus_addr_q;
  assign bus_wdata    = bus_wdata_q;
  assign bus_be       = bus_be_q;
  assign o_rdata      = o_rdata_q;
  assign o_misaligned = mis_q;
  assign o_bus_err    = err_q;

endmodule
